image_rom_window_sched: RTL and testbench
=========================================

Name: image_rom_window_sched

Overview:
- Sequences the dual-port 64x64 image ROM (12-bit address, 13-bit pixel, two combinational read ports).
- Performs one raster scan and assembles a zero-padded 3x3 neighbourhood window for every pixel.
- Delivers each window to the downstream 2-kernel convolution stage over a valid/ready handshake.
- Each window's 9 taps are fetched two per cycle, one on each ROM port.

Parameters:
- IMG_W, 64, image width in pixels.
- IMG_H, 64, image height in pixels.
- ADDR_W, 12, ROM address width; IMG_W*IMG_H <= 2^ADDR_W.
- DATA_W, 13, pixel width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a frame scan; honoured only in IDLE.
- rom_addr1  out  ADDR_W  ROM port-1 address, registered.
- rom_addr2  out  ADDR_W  ROM port-2 address, registered.
- rom_data1  in  DATA_W  ROM port-1 data; valid combinationally for the current rom_addr1.
- rom_data2  in  DATA_W  ROM port-2 data; valid combinationally for the current rom_addr2.
- win_data  out  9*DATA_W  window; tap t occupies bits [t*DATA_W +: DATA_W].
- win_x  out  6  centre column of the presented window.
- win_y  out  6  centre row of the presented window.
- win_valid  out  1  window presented.
- win_ready  in  1  downstream accepts the window.
- win_last  out  1  presented window is the final pixel (IMG_W-1, IMG_H-1).
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last window is accepted.

Behaviour:
- Reset: state IDLE; x=y=0; rom_addr1, rom_addr2, win_data, win_x, win_y all 0; win_valid, win_last, busy, done all 0.
- Tap numbering: t = (dy+1)*3 + (dx+1), with dy,dx in {-1,0,1}. Tap t reads pixel (x+dx, y+dy); linear address = (y+dy)*IMG_W + (x+dx).
- Padding: a tap outside 0..IMG_W-1 or 0..IMG_H-1 captures 0. The port for an out-of-range tap is driven with address 0 and its data is ignored. Out-of-range or wrapped addresses are never issued.
- States: IDLE, FETCH, PRESENT, DONE.
- IDLE:
  - start=1 -> FETCH with slot=0; addresses for slot 0 are loaded at the same edge.
  - start=0 -> remain in IDLE.
- FETCH (slot 0..4, one cycle each):
  - Slot k: port 1 carries tap 2k; port 2 carries tap 2k+1.
  - Slot 4: port 1 carries tap 8; port 2 is idle (address 0, data discarded).
  - At each edge, rom_data1/2 are captured into the addressed tap registers and the next slot's addresses are loaded.
  - After the slot-4 edge -> PRESENT.
- PRESENT:
  - win_valid=1; win_data, win_x, win_y, win_last are held stable until a handshake.
  - Handshake = win_valid & win_ready at an edge.
  - Handshake on a non-last window: advance x, wrapping to 0 and incrementing y at x=IMG_W-1; go to FETCH slot 0; win_valid drops to 0 at that edge.
  - Handshake on the last window: go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. x and y reset to 0.
- Timing: start sampled at edge 0 -> win_valid high after edge 5. With win_ready held high, each window costs 6 cycles, so window n is accepted at edge 6(n+1).
- start while busy is ignored. A new start is accepted in IDLE only, i.e. from the cycle after done at the earliest.
- win_ready asserted while win_valid=0 has no effect.
- rst asserted in any state, including mid-FETCH or PRESENT, returns the block to reset values at that edge. Partial windows are discarded.

Test Plan:
- ROM loaded with rom[a]=a, start pulse, win_ready=1 -> first window (0,0) taps = {0,0,0,0,0,1,0,64,65}; win_valid rises after edge 5.
- Same setup, window at x=10, y=5 -> taps = {265,266,267,329,330,331,393,394,395}; win_last=0.
- Last window (63,63) -> taps = {4030,4031,0,4094,4095,0,0,0,0}; win_last=1; done pulses exactly one cycle, at edge 24576 after start; 4096 handshakes counted in total.
- Backpressure: hold win_ready=0 for 10 cycles during PRESENT -> win_data, win_x, win_y, win_valid unchanged. Then raise win_ready -> exactly one handshake; next window valid 6 cycles later.
- Assert rst during FETCH slot 2 -> next cycle all outputs 0, state IDLE. A subsequent start rescans from (0,0) with correct taps.
- Pulse start while busy (mid-frame) -> scan order and timing unchanged, no restart. Start in the cycle after done -> new frame begins.
- Monitor on every cycle: no issued address >= 4096; every padded tap reads as 0.

Source files
------------

// File: rtl/image_rom_window_sched.sv
// Raster-scans a dual-port image ROM and presents a zero-padded 3x3 window per pixel
// over valid/ready; taps are fetched two per cycle, one on each ROM port.
module image_rom_window_sched #(
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 64,
    parameter int ADDR_W = 12,
    parameter int DATA_W = 13
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic [ADDR_W-1:0]   rom_addr1,
    output logic [ADDR_W-1:0]   rom_addr2,
    input  logic [DATA_W-1:0]   rom_data1,
    input  logic [DATA_W-1:0]   rom_data2,
    output logic [9*DATA_W-1:0] win_data,
    output logic [5:0]          win_x,
    output logic [5:0]          win_y,
    output logic                win_valid,
    input  logic                win_ready,
    output logic                win_last,
    output logic                busy,
    output logic                done
);

    typedef enum logic [1:0] {IDLE, FETCH, PRESENT, DONE} state_t;

    typedef struct packed {
        logic              ok;
        logic [ADDR_W-1:0] addr;
    } tap_t;

    state_t     state;
    logic [2:0] slot;
    logic       ok1, ok2;
    logic       at_row_end;
    logic [5:0] nx, ny, ld_x, ld_y;
    logic [2:0] ld_slot;
    logic [3:0] cur_t;
    tap_t       p1, p2;

    // Tap t of the window centred on (px,py); out-of-image taps get ok=0 and address 0.
    function automatic tap_t lookup(input logic [5:0] px, input logic [5:0] py,
                                    input logic [3:0] t);
        tap_t r;
        int   tx, ty;
        tx     = int'(px) + int'(t) % 3 - 1;
        ty     = int'(py) + int'(t) / 3 - 1;
        r.ok   = (t < 4'd9) && (tx >= 0) && (tx < IMG_W) && (ty >= 0) && (ty < IMG_H);
        r.addr = r.ok ? ADDR_W'(ty * IMG_W + tx) : '0;
        return r;
    endfunction

    // Addresses for the slot that the next edge will load.
    always_comb begin
        at_row_end = (win_x == 6'(IMG_W - 1));
        nx         = at_row_end ? 6'd0 : win_x + 6'd1;
        ny         = at_row_end ? win_y + 6'd1 : win_y;
        ld_x       = win_x;
        ld_y       = win_y;
        ld_slot    = slot + 3'd1;
        case (state)
            IDLE: begin
                ld_x    = '0;
                ld_y    = '0;
                ld_slot = '0;
            end
            PRESENT: begin
                ld_x    = nx;
                ld_y    = ny;
                ld_slot = '0;
            end
            default: ;
        endcase
        p1    = lookup(ld_x, ld_y, {ld_slot, 1'b0});
        p2    = lookup(ld_x, ld_y, {ld_slot, 1'b1});
        cur_t = {slot, 1'b0};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            slot      <= '0;
            ok1       <= 1'b0;
            ok2       <= 1'b0;
            rom_addr1 <= '0;
            rom_addr2 <= '0;
            // NOTE: the tap storage doubles as the win_data output register, so it is
            // reset along with the control state rather than left uninitialised.
            win_data  <= '0;
            win_x     <= '0;
            win_y     <= '0;
            win_valid <= 1'b0;
            win_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            // NOTE: all state here uses <= so every read sees the pre-edge value.
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= FETCH;
                        slot      <= '0;
                        busy      <= 1'b1;
                        rom_addr1 <= p1.addr;
                        rom_addr2 <= p2.addr;
                        ok1       <= p1.ok;
                        ok2       <= p2.ok;
                    end
                end
                FETCH: begin
                    win_data[int'(cur_t)*DATA_W +: DATA_W] <= ok1 ? rom_data1 : '0;
                    if (slot != 3'd4)
                        win_data[int'(cur_t)*DATA_W + DATA_W +: DATA_W] <= ok2 ? rom_data2 : '0;
                    if (slot == 3'd4) begin
                        state     <= PRESENT;
                        win_valid <= 1'b1;
                        win_last  <= at_row_end && (win_y == 6'(IMG_H - 1));
                        rom_addr1 <= '0;
                        rom_addr2 <= '0;
                        ok1       <= 1'b0;
                        ok2       <= 1'b0;
                    end else begin
                        slot      <= ld_slot;
                        rom_addr1 <= p1.addr;
                        rom_addr2 <= p2.addr;
                        ok1       <= p1.ok;
                        ok2       <= p2.ok;
                    end
                end
                PRESENT: begin
                    if (win_ready) begin
                        win_valid <= 1'b0;
                        win_last  <= 1'b0;
                        if (win_last) begin
                            state <= DONE;
                            done  <= 1'b1;
                            win_x <= '0;
                            win_y <= '0;
                        end else begin
                            state     <= FETCH;
                            slot      <= '0;
                            win_x     <= nx;
                            win_y     <= ny;
                            rom_addr1 <= p1.addr;
                            rom_addr2 <= p2.addr;
                            ok1       <= p1.ok;
                            ok2       <= p2.ok;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_image_rom_window_sched.sv
// Directed bench for image_rom_window_sched: ROM holds rom[a]=a; checks windows,
// handshake timing, backpressure, mid-fetch reset and start filtering.
module tb_image_rom_window_sched;

    logic         clk = 1'b0;
    logic         rst, start, win_ready;
    logic [11:0]  rom_addr1, rom_addr2;
    logic [12:0]  rom_data1, rom_data2;
    logic [116:0] win_data;
    logic [5:0]   win_x, win_y;
    logic         win_valid, win_last, busy, done;

    int vectors     = 0;
    int miscompares = 0;
    int edge_cnt    = 0;
    int sb_n        = 0;
    int hs_cnt      = 0;

    logic [116:0] cap [4096];
    bit           cap_last [4096];
    bit           cap_seen [4096];

    typedef struct {
        int x;
        int y;
        int taps[9];
        bit last;
    } vec_t;
    vec_t vecs[6];

    image_rom_window_sched dut (
        .clk(clk), .rst(rst), .start(start),
        .rom_addr1(rom_addr1), .rom_addr2(rom_addr2),
        .rom_data1(rom_data1), .rom_data2(rom_data2),
        .win_data(win_data), .win_x(win_x), .win_y(win_y),
        .win_valid(win_valid), .win_ready(win_ready), .win_last(win_last),
        .busy(busy), .done(done)
    );

    assign rom_data1 = 13'(rom_addr1);
    assign rom_data2 = 13'(rom_addr2);

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [116:0] exp_win(input int x, input int y);
        logic [116:0] w;
        int tx, ty;
        w = '0;
        for (int t = 0; t < 9; t++) begin
            tx = x + t % 3 - 1;
            ty = y + t / 3 - 1;
            if (tx >= 0 && tx < 64 && ty >= 0 && ty < 64)
                w[t*13 +: 13] = 13'(ty * 64 + tx);
        end
        return w;
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_addr"}, {rom_addr1, rom_addr2}, 0);
        check({tag, "_data"}, win_data, 0);
        check({tag, "_xy"}, {win_x, win_y}, 0);
        check({tag, "_flags"}, {win_valid, win_last, busy, done}, 0);
    endtask

    // Scoreboard: every handshake must present the next raster window in order.
    always @(negedge clk) begin
        #2;
        if (!rst && win_valid && win_ready) begin
            check($sformatf("window_%0d", sb_n),
                  {win_last, win_y, win_x, win_data},
                  {sb_n == 4095, 6'(sb_n / 64), 6'(sb_n % 64), exp_win(sb_n % 64, sb_n / 64)});
            cap[{win_y, win_x}]      = win_data;
            cap_last[{win_y, win_x}] = win_last;
            cap_seen[{win_y, win_x}] = 1'b1;
            sb_n++;
            hs_cnt++;
        end
    end

    initial begin
        int e0, h;
        logic [116:0] snap, w;

        vecs[0] = '{0, 0, '{0, 0, 0, 0, 0, 1, 0, 64, 65}, 1'b0};
        vecs[1] = '{10, 5, '{265, 266, 267, 329, 330, 331, 393, 394, 395}, 1'b0};
        vecs[2] = '{63, 63, '{4030, 4031, 0, 4094, 4095, 0, 0, 0, 0}, 1'b1};
        vecs[3] = '{63, 0, '{0, 0, 0, 62, 63, 0, 126, 127, 0}, 1'b0};
        vecs[4] = '{0, 63, '{0, 3968, 3969, 0, 4032, 4033, 0, 0, 0}, 1'b0};
        vecs[5] = '{1, 1, '{0, 1, 2, 64, 65, 66, 128, 129, 130}, 1'b0};

        rst = 1'b1; start = 1'b0; win_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_idle("reset");
        rst = 1'b0;

        // Frame 1: free-running, with a stray start pulse mid-frame.
        @(negedge clk);
        start = 1'b1; win_ready = 1'b1; sb_n = 0; hs_cnt = 0;
        @(negedge clk);
        start = 1'b0; e0 = edge_cnt;
        check("f1_busy_valid", {busy, win_valid}, 2'b10);
        repeat (4) @(negedge clk);
        check("f1_valid_edge4", win_valid, 0);
        @(negedge clk);
        check("f1_valid_edge5", win_valid, 1);
        check("f1_first_taps", win_data, exp_win(0, 0));
        while (!done && (edge_cnt - e0) < 25000) begin
            @(negedge clk);
            start = ((edge_cnt - e0) == 1000);
        end
        start = 1'b0;
        check("f1_done_seen", done, 1);
        check("f1_done_edge", edge_cnt - e0, 24576);
        check("f1_handshakes", hs_cnt, 4096);

        for (int i = 0; i < 6; i++) begin
            w = '0;
            for (int t = 0; t < 9; t++) w[t*13 +: 13] = 13'(vecs[i].taps[t]);
            check($sformatf("table_%0d_%0d", vecs[i].x, vecs[i].y),
                  {cap_seen[vecs[i].y*64 + vecs[i].x], cap_last[vecs[i].y*64 + vecs[i].x],
                   cap[vecs[i].y*64 + vecs[i].x]},
                  {1'b1, vecs[i].last, w});
        end

        // Frame 2: start in the cycle after done, then backpressure.
        win_ready = 1'b0;
        @(negedge clk);
        check("done_one_cycle", {done, busy}, 0);
        start = 1'b1; sb_n = 0; hs_cnt = 0;
        @(negedge clk);
        start = 1'b0;
        check("f2_started", busy, 1);
        repeat (5) @(negedge clk);
        check("f2_valid", {win_valid, win_x, win_y}, {1'b1, 12'd0});
        snap = win_data;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_hold", {win_valid, win_x, win_y, win_data}, {1'b1, 12'd0, snap});
        end
        win_ready = 1'b1;
        @(negedge clk);
        win_ready = 1'b0;
        h = edge_cnt;
        check("bp_one_hs", {hs_cnt, win_valid, win_x}, {32'd1, 1'b0, 6'd1});
        repeat (4) @(negedge clk);
        check("bp_next_edge4", win_valid, 0);
        @(negedge clk);
        check("bp_next_edge5", {win_valid, win_x, edge_cnt - h}, {1'b1, 6'd1, 32'd5});

        // Handshake, then reset while slot 2 addresses are on the ports.
        win_ready = 1'b1;
        @(negedge clk);
        win_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("pre_rst_busy", {busy, win_valid}, 2'b10);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle("mid_rst");

        // Frame 3 restarts from (0,0).
        start = 1'b1; win_ready = 1'b1; sb_n = 0; hs_cnt = 0;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 40 && hs_cnt < 3; i++) @(negedge clk);
        check("f3_restart_hs", hs_cnt, 3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
